ws2812_driver: RTL and testbench

WS2812_DRIVER -- requirements
Module: ws2812_driver

---
 rtl/ws2812_pkg.sv | 18 +
 rtl/ws2812_bit_timer.sv | 51 +++++
 rtl/ws2812_driver.sv | 136 +++++++++++++
 tb/tb_ws2812_driver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared state type and default WS2812 timing at 10 MHz
package ws2812_pkg;

    localparam int DEF_NUM_LEDS = 3;
    localparam int DEF_T0H_CYC  = 4;
    localparam int DEF_T1H_CYC  = 8;
    localparam int DEF_BIT_CYC  = 12;
    localparam int DEF_RST_CYC  = 600;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_WAIT,
        ST_LATCH
    } state_t;

endpackage

// File: rtl/ws2812_bit_timer.sv
// rtl/ws2812_bit_timer.sv - one WS2812 bit period: high phase then low phase
module ws2812_bit_timer
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC,
    parameter int BIT_CYC = DEF_BIT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_val,
    output logic high_end,
    output logic bit_last
);

    localparam int CW = $clog2(BIT_CYC);
    localparam logic [CW-1:0] T0H_LAST = CW'(T0H_CYC - 1);
    localparam logic [CW-1:0] T1H_LAST = CW'(T1H_CYC - 1);
    localparam logic [CW-1:0] L0_LAST  = CW'(BIT_CYC - T0H_CYC - 1);
    localparam logic [CW-1:0] L1_LAST  = CW'(BIT_CYC - T1H_CYC - 1);

    logic          active;
    logic          high;
    logic [CW-1:0] cnt;

    // bit_val is the live shift-register MSB; it is stable for the whole bit
    assign high_end = active && high && (cnt == (bit_val ? T1H_LAST : T0H_LAST));
    assign bit_last = active && !high && (cnt == (bit_val ? L1_LAST : L0_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            high   <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            high   <= 1'b1;
            cnt    <= '0;
        end else if (high_end) begin
            high <= 1'b0;
            cnt  <= '0;
        end else if (bit_last) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (active) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ws2812_driver.sv
// rtl/ws2812_driver.sv - WS2812 serial LED frame driver with pixel handshake
module ws2812_driver
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T0H_CYC  = DEF_T0H_CYC,
    parameter int T1H_CYC  = DEF_T1H_CYC,
    parameter int BIT_CYC  = DEF_BIT_CYC,
    parameter int RST_CYC  = DEF_RST_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       dout,
    output logic       busy,
    output logic       frame_done
);

    localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int RW = $clog2(RST_CYC);
    localparam logic [PW-1:0] PIX_LAST = PW'(NUM_LEDS - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);

    state_t        state, state_nxt;
    logic [23:0]   sreg;
    logic [4:0]    bit_cnt;
    logic [PW-1:0] pix_cnt;
    logic [RW-1:0] rst_cnt;
    logic          armed;
    logic          load, advance;
    logic          high_end, bit_last;

    ws2812_bit_timer #(
        .T0H_CYC(T0H_CYC),
        .T1H_CYC(T1H_CYC),
        .BIT_CYC(BIT_CYC)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (load | advance),
        .bit_val (sreg[23]),
        .high_end(high_end),
        .bit_last(bit_last)
    );

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_IDLE: begin
                // armed holds ready low until the first edge after reset release
                pix_ready = armed;
                if (armed && pix_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (high_end) state_nxt = ST_LOW;
            end
            ST_LOW: begin
                if (bit_last) begin
                    if (bit_cnt != 5'd0) begin
                        advance   = 1'b1;
                        state_nxt = ST_HIGH;
                    end else if (pix_cnt == PIX_LAST) begin
                        state_nxt = ST_LATCH;
                    end else begin
                        pix_ready = 1'b1;
                        if (pix_valid) begin
                            load      = 1'b1;
                            state_nxt = ST_HIGH;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_HIGH;
                end else if (rst_cnt == RST_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LATCH: begin
                if (rst_cnt == RST_LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            armed      <= 1'b0;
            dout       <= 1'b0;
            frame_done <= 1'b0;
            sreg       <= '0;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            rst_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            armed      <= 1'b1;
            dout       <= (state_nxt == ST_HIGH);
            frame_done <= (state == ST_LATCH) && (state_nxt == ST_IDLE);

            if (state_nxt != state) rst_cnt <= '0;
            else if (state == ST_WAIT || state == ST_LATCH) rst_cnt <= rst_cnt + 1'b1;

            if (load) begin
                sreg    <= {pix_g, pix_r, pix_b};
                bit_cnt <= 5'd23;
            end else if (advance) begin
                sreg    <= {sreg[22:0], 1'b0};
                bit_cnt <= bit_cnt - 1'b1;
            end

            // a WAIT timeout also lands here, dropping the partial frame count
            if (state_nxt == ST_IDLE) pix_cnt <= '0;
            else if (load && state != ST_IDLE) pix_cnt <= pix_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ws2812_driver.sv
// tb/tb_ws2812_driver.sv - randomized self-checking bench with waveform-queue model
module tb_ws2812_driver;

    localparam int NL   = 2;
    localparam int T0H  = 4;
    localparam int T1H  = 8;
    localparam int BITC = 12;
    localparam int RSTC = 600;

    localparam int M_IDLE  = 0;
    localparam int M_SEND  = 1;
    localparam int M_WAIT  = 2;
    localparam int M_LATCH = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pix_r = 8'h00, pix_g = 8'h00, pix_b = 8'h00;
    logic       pix_valid = 1'b0;
    logic       pix_ready, dout, busy, frame_done;

    always #5 clk = ~clk;

    ws2812_driver #(
        .NUM_LEDS(NL),
        .T0H_CYC (T0H),
        .T1H_CYC (T1H),
        .BIT_CYC (BITC),
        .RST_CYC (RSTC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_r     (pix_r),
        .pix_g     (pix_g),
        .pix_b     (pix_b),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .dout      (dout),
        .busy      (busy),
        .frame_done(frame_done)
    );

    int checks = 0;
    int errors = 0;

    // model: queue of expected dout samples for the pixel(s) in flight
    bit wave[$];
    int m_mode = M_IDLE;
    int m_cnt = 0;
    int m_pix = 0;
    bit m_done = 0;
    bit m_armed = 0;
    bit m_acc = 0;

    int meas_busy = 0;
    int meas_high = 0;
    int meas_fd = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL timeout %s actual=expired required=event at %0t", name, $time);
    endtask

    task automatic model_reset();
        wave.delete();
        m_mode = M_IDLE;
        m_cnt = 0;
        m_pix = 0;
        m_done = 0;
        m_armed = 0;
        m_acc = 0;
    endtask

    task automatic push_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [23:0] w;
        w = {g, r, b};
        for (int i = 23; i >= 0; i--) begin
            int h;
            h = w[i] ? T1H : T0H;
            for (int c = 0; c < BITC; c++) wave.push_back(c < h);
        end
    endtask

    function automatic bit exp_ready();
        return m_armed && (m_mode == M_IDLE || m_mode == M_WAIT ||
                           (m_mode == M_SEND && wave.size() == 1 && m_pix < NL));
    endfunction

    task automatic model_step();
        bit acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = exp_ready() && pix_valid;
        m_acc = acc;
        m_done = 0;
        m_armed = 1;
        case (m_mode)
            M_IDLE: if (acc) begin
                push_pixel(pix_r, pix_g, pix_b);
                m_pix = 1;
                m_mode = M_SEND;
            end
            M_SEND: begin
                void'(wave.pop_front());
                if (acc) begin
                    push_pixel(pix_r, pix_g, pix_b);
                    m_pix++;
                end else if (wave.size() == 0) begin
                    m_cnt = 0;
                    m_mode = (m_pix == NL) ? M_LATCH : M_WAIT;
                end
            end
            M_WAIT: begin
                if (acc) begin
                    push_pixel(pix_r, pix_g, pix_b);
                    m_pix++;
                    m_mode = M_SEND;
                end else begin
                    m_cnt++;
                    if (m_cnt == RSTC) begin
                        m_mode = M_IDLE;
                        m_pix = 0;
                    end
                end
            end
            default: begin
                m_cnt++;
                if (m_cnt == RSTC) begin
                    m_mode = M_IDLE;
                    m_done = 1;
                    m_pix = 0;
                end
            end
        endcase
    endtask

    // compare at negedge, then let the edge happen and advance the model
    task automatic cycle();
        int ed;
        ed = (m_mode == M_SEND && wave.size() > 0) ? int'(wave[0]) : 0;
        check("dout", int'(dout), ed);
        check("pix_ready", int'(pix_ready), int'(exp_ready()));
        check("busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
        check("frame_done", int'(frame_done), int'(m_done));
        if (busy) meas_busy++;
        if (dout) meas_high++;
        if (frame_done) meas_fd++;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic rand_data();
        pix_r = 8'($urandom);
        pix_g = 8'($urandom);
        pix_b = 8'($urandom);
    endtask

    task automatic set_pix(input logic [23:0] p);
        pix_r = p[23:16];
        pix_g = p[15:8];
        pix_b = p[7:0];
    endtask

    // p0/p1 given as {r,g,b}; gap<0 means the second pixel never arrives
    task automatic run_frame(input logic [23:0] p0, input logic [23:0] p1, input int gap,
                             input int exp_busy, input int exp_high);
        int n;
        meas_busy = 0;
        meas_high = 0;
        meas_fd = 0;
        set_pix(p0);
        pix_valid = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!m_acc && n < 50);
        if (!m_acc) timeout("accept_p0");
        if (gap == 0) begin
            set_pix(p1);
            n = 0;
            do begin cycle(); n++; end while (!m_acc && n < 400);
            if (!m_acc) timeout("accept_p1_early");
        end else begin
            pix_valid = 1'b0;
            n = 0;
            while (m_mode != M_WAIT && n < 400) begin rand_data(); cycle(); n++; end
            if (m_mode != M_WAIT) timeout("enter_wait");
            if (gap < 0) begin
                n = 0;
                while (m_mode != M_IDLE && n < RSTC + 10) begin rand_data(); cycle(); n++; end
                if (m_mode != M_IDLE) timeout("wait_abort");
            end else begin
                repeat (gap) begin rand_data(); cycle(); end
                set_pix(p1);
                pix_valid = 1'b1;
                n = 0;
                do begin cycle(); n++; end while (!m_acc && n < 5);
                if (!m_acc) timeout("accept_p1_late");
            end
        end
        n = 0;
        while (m_mode != M_IDLE && n < 2000) begin
            rand_data();
            pix_valid = (m_mode == M_SEND || m_mode == M_LATCH) ? 1'($urandom) : 1'b0;
            cycle();
            n++;
        end
        if (m_mode != M_IDLE) timeout("frame_end");
        pix_valid = 1'b0;
        repeat (3) cycle();
        check("busy_len", meas_busy, exp_busy);
        if (exp_high >= 0) check("high_cycles", meas_high, exp_high);
        check("frame_done_cnt", meas_fd, (gap < 0) ? 0 : 1);
    endtask

    initial begin
        logic [23:0] p0, p1;
        int g, sel;
        model_reset();
        @(negedge clk);
        check("rst_dout", int'(dout), 0);
        check("rst_ready", int'(pix_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        cycle();
        rst_n = 1'b1;
        check("ready_before_edge", int'(pix_ready), 0);
        cycle();
        check("ready_after_release", int'(pix_ready), 1);

        // G=FF pixel then black pixel offered early: no gap between pixels
        run_frame(24'h00FF00, 24'h000000, 0, 2 * 24 * BITC + RSTC, 224);
        // second pixel 50 WAIT cycles late
        run_frame(24'hA55A3C, 24'h000000, 49, 2 * 24 * BITC + RSTC + 50, 240);
        // second pixel never arrives: abort after RST_CYC of WAIT
        run_frame(24'h00FF00, 24'h000000, -1, 24 * BITC + RSTC, 128);

        // reset during bit 10 of pixel 0
        set_pix(24'h123456);
        pix_valid = 1'b1;
        cycle();
        pix_valid = 1'b0;
        repeat (125) cycle();
        rst_n = 1'b0;
        #1;
        check("midrst_dout", int'(dout), 0);
        check("midrst_ready", int'(pix_ready), 0);
        check("midrst_busy", int'(busy), 0);
        model_reset();
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        cycle();
        check("midrst_ready_release", int'(pix_ready), 1);
        run_frame(24'hA55A3C, 24'h000000, 0, 2 * 24 * BITC + RSTC, 240);

        for (int f = 0; f < 8; f++) begin
            p0 = 24'($urandom);
            p1 = 24'($urandom);
            sel = $urandom_range(0, 3);
            if (sel == 0) g = 0;
            else if (sel == 3) g = ($urandom_range(0, 2) == 0) ? -1 : 0;
            else g = $urandom_range(1, 120);
            run_frame(p0, p1, g,
                      (g < 0) ? 24 * BITC + RSTC :
                      (g == 0) ? 2 * 24 * BITC + RSTC : 2 * 24 * BITC + RSTC + g + 1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
